// File: rtl/tow_pkg.sv
// Shared types and default sizing for the tug-of-war rope game.
package tow_pkg;

  typedef enum logic [1:0] {
    ST_PLAY     = 2'd0,
    ST_WAIT_REL = 2'd1,
    ST_WIN_L    = 2'd2,
    ST_WIN_R    = 2'd3
  } state_e;

  localparam int NPOS_DEF        = 7;
  localparam int DEB_SAMPLES_DEF = 3;

endpackage

// File: rtl/pb_cond.sv
// Pushbutton conditioner: 2-flop synchronizer, slowen-paced debounce counter,
// and a registered rising-edge press pulse.
module pb_cond #(
  parameter int DEB_SAMPLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic slowen,
  input  logic pb,
  output logic deb,
  output logic press
);

  logic       sync1_q, sync2_q;
  logic       deb_q, deb_d;
  logic [3:0] cnt_q, cnt_d;
  logic       press_q, press_d;

  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (slowen) begin
      if (sync2_q != deb_q) begin
        // Level flips on the sample that completes the run of disagreeing samples.
        if (cnt_q + 4'd1 == 4'(DEB_SAMPLES)) begin
          deb_d = sync2_q;
          cnt_d = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end else begin
        cnt_d = 4'd0;
      end
    end
    press_d = deb_d & ~deb_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= 4'd0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= pb;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign deb   = deb_q;
  assign press = press_q;

endmodule

// File: rtl/rope_fsm.sv
// Tug-of-war rope game: two conditioned buttons pull a one-hot rope marker;
// reaching an end and pulling again wins, with the end LED blinking on slowen.
module rope_fsm
  import tow_pkg::*;
#(
  parameter int NPOS        = NPOS_DEF,
  parameter int DEB_SAMPLES = DEB_SAMPLES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            slowen,
  input  logic            pbl,
  input  logic            pbr,
  input  logic            restart,
  output logic [NPOS-1:0] leds,
  output logic            winner_l,
  output logic            winner_r
);

  localparam int PW = $clog2(NPOS);
  localparam logic [PW-1:0]   CENTRE = PW'((NPOS - 1) / 2);
  localparam logic [PW-1:0]   POS_MAX = PW'(NPOS - 1);
  localparam logic [NPOS-1:0] ONE = NPOS'(1);
  localparam logic [NPOS-1:0] MSB = ONE << (NPOS - 1);

  logic deb_l, deb_r, press_l, press_r;

  pb_cond #(.DEB_SAMPLES(DEB_SAMPLES)) u_pbl (
    .clk(clk), .rst(rst), .slowen(slowen), .pb(pbl), .deb(deb_l), .press(press_l)
  );

  pb_cond #(.DEB_SAMPLES(DEB_SAMPLES)) u_pbr (
    .clk(clk), .rst(rst), .slowen(slowen), .pb(pbr), .deb(deb_r), .press(press_r)
  );

  state_e          state_q, state_d;
  logic [PW-1:0]   pos_q, pos_d;
  logic [NPOS-1:0] leds_q, leds_d;
  logic            winner_l_q, winner_l_d;
  logic            winner_r_q, winner_r_d;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    case (state_q)
      ST_PLAY: begin
        if (press_l && !press_r) begin
          if (pos_q == POS_MAX) state_d = ST_WIN_L;
          else begin
            pos_d   = pos_q + PW'(1);
            state_d = ST_WAIT_REL;
          end
        end else if (press_r && !press_l) begin
          if (pos_q == '0) state_d = ST_WIN_R;
          else begin
            pos_d   = pos_q - PW'(1);
            state_d = ST_WAIT_REL;
          end
        end else if (press_l && press_r) begin
          state_d = ST_WAIT_REL;
        end
      end
      ST_WAIT_REL: if (!deb_l && !deb_r) state_d = ST_PLAY;
      ST_WIN_L, ST_WIN_R: begin
        if (restart) begin
          pos_d   = CENTRE;
          state_d = ST_WAIT_REL;
        end
      end
      default: state_d = ST_PLAY;
    endcase

    // Display follows the next state so every output is a plain register.
    case (state_d)
      ST_WIN_L: leds_d = (state_q == ST_WIN_L) ? (leds_q ^ (slowen ? MSB : '0)) : MSB;
      ST_WIN_R: leds_d = (state_q == ST_WIN_R) ? (leds_q ^ (slowen ? ONE : '0)) : ONE;
      default:  leds_d = ONE << pos_d;
    endcase
    winner_l_d = (state_d == ST_WIN_L);
    winner_r_d = (state_d == ST_WIN_R);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_PLAY;
      pos_q      <= CENTRE;
      leds_q     <= ONE << CENTRE;
      winner_l_q <= 1'b0;
      winner_r_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      leds_q     <= leds_d;
      winner_l_q <= winner_l_d;
      winner_r_q <= winner_r_d;
    end
  end

  assign leds     = leds_q;
  assign winner_l = winner_l_q;
  assign winner_r = winner_r_q;

endmodule

// File: tb/tb_rope_fsm.sv
// Directed bench for rope_fsm with NPOS=7, DEB_SAMPLES=3 and slowen every 4 clks.
module tb_rope_fsm;
  import tow_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       slowen = 1'b0;
  logic       pbl = 1'b0, pbr = 1'b0, restart = 1'b0;
  logic [6:0] leds;
  logic       winner_l, winner_r;
  int         n_chk = 0, n_fail = 0;
  int         div_cnt = 0;

  rope_fsm #(.NPOS(7), .DEB_SAMPLES(3)) dut (
    .clk(clk), .rst(rst), .slowen(slowen), .pbl(pbl), .pbr(pbr),
    .restart(restart), .leds(leds), .winner_l(winner_l), .winner_r(winner_r)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    slowen  = (div_cnt == 3);
    div_cnt = (div_cnt + 1) % 4;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic l, input logic r);
    pbl = l; pbr = r;
    wait_clks(24);
    pbl = 1'b0; pbr = 1'b0;
    wait_clks(24);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    wait_clks(2);
  endtask

  task automatic do_restart();
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
  endtask

  task automatic test_reset();
    n_chk++; if (leds !== 7'b0001000) begin n_fail++; $display("FAIL reset_leds got=%b exp=%b", leds, 7'b0001000); end
    n_chk++; if ({winner_l, winner_r} !== 2'b00) begin n_fail++; $display("FAIL reset_winners got=%b exp=00", {winner_l, winner_r}); end
    pbl = 1'b1; wait_clks(8); pbl = 1'b0; wait_clks(24);
    n_chk++; if (leds !== 7'b0001000) begin n_fail++; $display("FAIL glitch_nomove got=%b exp=%b", leds, 7'b0001000); end
  endtask

  task automatic test_single_press();
    bit seen = 0;
    pbl = 1'b1;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (dut.u_pbl.press_q === 1'b1) seen = 1;
    end
    n_chk++; if (!seen) begin n_fail++; $display("FAIL press_timeout got=0 exp=1"); end
    n_chk++; if (leds !== 7'b0001000) begin n_fail++; $display("FAIL leds_at_pulse got=%b exp=%b", leds, 7'b0001000); end
    @(negedge clk);
    n_chk++; if (leds !== 7'b0010000) begin n_fail++; $display("FAIL leds_after_pulse got=%b exp=%b", leds, 7'b0010000); end
    wait_clks(32);
    n_chk++; if (leds !== 7'b0010000) begin n_fail++; $display("FAIL hold_nomove got=%b exp=%b", leds, 7'b0010000); end
    n_chk++; if (dut.state_q !== ST_WAIT_REL) begin n_fail++; $display("FAIL hold_state got=%0d exp=%0d", dut.state_q, ST_WAIT_REL); end
    pbl = 1'b0; wait_clks(24);
    n_chk++; if (dut.state_q !== ST_PLAY) begin n_fail++; $display("FAIL release_state got=%0d exp=%0d", dut.state_q, ST_PLAY); end
  endtask

  task automatic test_simultaneous();
    pbl = 1'b1; pbr = 1'b1; wait_clks(24);
    n_chk++; if (leds !== 7'b0010000) begin n_fail++; $display("FAIL simul_leds got=%b exp=%b", leds, 7'b0010000); end
    n_chk++; if (dut.state_q !== ST_WAIT_REL) begin n_fail++; $display("FAIL simul_state got=%0d exp=%0d", dut.state_q, ST_WAIT_REL); end
    pbl = 1'b0; wait_clks(24);
    n_chk++; if (dut.state_q !== ST_WAIT_REL) begin n_fail++; $display("FAIL simul_one_rel got=%0d exp=%0d", dut.state_q, ST_WAIT_REL); end
    pbr = 1'b0; wait_clks(24);
    n_chk++; if (dut.state_q !== ST_PLAY) begin n_fail++; $display("FAIL simul_both_rel got=%0d exp=%0d", dut.state_q, ST_PLAY); end
    n_chk++; if (leds !== 7'b0010000) begin n_fail++; $display("FAIL simul_end_leds got=%b exp=%b", leds, 7'b0010000); end
  endtask

  task automatic test_win_l();
    logic b0;
    do_reset();
    press(1, 0); press(1, 0); press(1, 0);
    n_chk++; if (leds !== 7'b1000000) begin n_fail++; $display("FAIL left_end got=%b exp=%b", leds, 7'b1000000); end
    press(1, 0);
    n_chk++; if ({winner_l, winner_r} !== 2'b10) begin n_fail++; $display("FAIL win_l_flags got=%b exp=10", {winner_l, winner_r}); end
    for (int k = 0; k < 2; k++) begin
      b0 = leds[6];
      wait_clks(4);
      n_chk++; if (leds[6] !== ~b0) begin n_fail++; $display("FAIL win_l_blink got=%b exp=%b", leds[6], ~b0); end
      n_chk++; if (leds[5:0] !== 6'b0) begin n_fail++; $display("FAIL win_l_others got=%b exp=000000", leds[5:0]); end
    end
    do_restart();
    n_chk++; if (leds !== 7'b0001000) begin n_fail++; $display("FAIL restart_l_leds got=%b exp=%b", leds, 7'b0001000); end
    n_chk++; if (winner_l !== 1'b0) begin n_fail++; $display("FAIL restart_l_winner got=%b exp=0", winner_l); end
    wait_clks(4);
  endtask

  task automatic test_win_r();
    press(0, 1); press(0, 1); press(0, 1);
    n_chk++; if (leds !== 7'b0000001) begin n_fail++; $display("FAIL right_end got=%b exp=%b", leds, 7'b0000001); end
    pbr = 1'b1; wait_clks(24);
    n_chk++; if ({winner_l, winner_r} !== 2'b01) begin n_fail++; $display("FAIL win_r_flags got=%b exp=01", {winner_l, winner_r}); end
    do_restart();
    n_chk++; if ({leds, winner_r} !== {7'b0001000, 1'b0}) begin n_fail++; $display("FAIL restart_r got=%b/%b exp=0001000/0", leds, winner_r); end
    wait_clks(32);
    n_chk++; if (leds !== 7'b0001000) begin n_fail++; $display("FAIL held_after_restart got=%b exp=%b", leds, 7'b0001000); end
    pbr = 1'b0; wait_clks(24);
    n_chk++; if (leds !== 7'b0001000) begin n_fail++; $display("FAIL release_after_restart got=%b exp=%b", leds, 7'b0001000); end
    press(0, 1);
    n_chk++; if (leds !== 7'b0000100) begin n_fail++; $display("FAIL repress_r got=%b exp=%b", leds, 7'b0000100); end
  endtask

  task automatic test_rst_mid();
    bit early = 0, moved = 0;
    do_reset();
    press(1, 0); press(1, 0);
    n_chk++; if (leds !== 7'b0100000) begin n_fail++; $display("FAIL pos5 got=%b exp=%b", leds, 7'b0100000); end
    pbl = 1'b1; wait_clks(7);
    #2 rst = 1'b1;
    #1;
    n_chk++; if (leds !== 7'b0001000) begin n_fail++; $display("FAIL async_rst_leds got=%b exp=%b", leds, 7'b0001000); end
    n_chk++; if (dut.u_pbl.cnt_q !== 4'd0) begin n_fail++; $display("FAIL async_rst_cnt got=%0d exp=0", dut.u_pbl.cnt_q); end
    wait_clks(3);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (dut.u_pbl.press_q !== 1'b0 || leds !== 7'b0001000) early = 1;
    end
    n_chk++; if (early) begin n_fail++; $display("FAIL early_press got=1 exp=0"); end
    for (int i = 0; i < 40 && !moved; i++) begin
      @(negedge clk);
      if (leds === 7'b0010000) moved = 1;
    end
    n_chk++; if (!moved) begin n_fail++; $display("FAIL held_press_after_rst got=%b exp=%b", leds, 7'b0010000); end
    pbl = 1'b0; wait_clks(24);
  endtask

  initial begin
    wait_clks(3);
    rst = 1'b0;
    wait_clks(2);
    test_reset();
    test_single_press();
    test_simultaneous();
    test_win_l();
    test_win_r();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  always @(negedge clk)
    if (!rst && winner_l && winner_r) begin
      n_fail++;
      $display("FAIL both_winners got=11 exp=not_11");
    end

endmodule

// File: doc/rope_fsm.md
ROPE_FSM -- requirements
Module: rope_fsm

Interface
REQ-001 Parameter: NPOS, 7, number of rope positions/LEDs; odd, 3..15.
REQ-002 Parameter: DEB_SAMPLES, 3, consecutive slowen samples required to accept a button level change; 1..15.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 slowen  input  1  one-clk enable strobe from the divider; the only debounce time base.
REQ-006 pbl  input  1  raw left pushbutton, asynchronous, active-high.
REQ-007 pbr  input  1  raw right pushbutton, asynchronous, active-high.
REQ-008 restart  input  1  synchronous new-game request, honoured only in a win state.
REQ-009 leds  output  NPOS  rope display; bit NPOS-1 = left end, bit 0 = right end.
REQ-010 winner_l  output  1  high while left has won.
REQ-011 winner_r  output  1  high while right has won.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer on clk before any other use.
REQ-013 The debounced level SHALL change only on a slowen cycle, and only when the synchronized level has differed from the debounced level on DEB_SAMPLES consecutive slowen cycles; any agreeing sample clears the count.
REQ-014 A press event SHALL be a one-clk registered pulse on the rising edge of the debounced level; a release generates no event.
REQ-015 State register SHALL hold position pos (0..NPOS-1) and state PLAY, WAIT_REL, WIN_L, WIN_R.
REQ-016 PLAY: left-only press with pos<NPOS-1 -> pos+1, WAIT_REL; left-only press with pos==NPOS-1 -> WIN_L.
REQ-017 PLAY: right-only press with pos>0 -> pos-1, WAIT_REL; right-only press with pos==0 -> WIN_R.
REQ-018 PLAY: simultaneous press events in the same cycle -> no move, WAIT_REL.
REQ-019 WAIT_REL: press events ignored; -> PLAY on the first cycle both debounced levels are 0.
REQ-020 pos, state and leds SHALL update on the clock edge after the press pulse (one-clk latency).
REQ-021 In PLAY and WAIT_REL, leds SHALL be one-hot at bit pos.
REQ-022 WIN_L: winner_l=1; leds[NPOS-1] toggles on every slowen cycle, all other bits 0; WIN_R mirrors on bit 0 with winner_r.
REQ-023 restart in WIN_L/WIN_R -> pos=(NPOS-1)/2, WAIT_REL, winners cleared, next edge; ignored in PLAY/WAIT_REL.
REQ-024 winner_l and winner_r SHALL never be high together.

Reset
REQ-025 rst SHALL asynchronously force: synchronizers, debounced levels, sample counts, press pulses 0; pos=(NPOS-1)/2; state PLAY; leds one-hot at centre (NPOS=7: 7'b0001000); winner_l=winner_r=0.
REQ-026 rst asserted mid-game or mid-debounce SHALL discard all pending counts; a button held through reset release SHALL produce a press only after DEB_SAMPLES strobes.

Structure
REQ-027 Package tow_pkg SHALL hold the state enumeration and default NPOS/DEB_SAMPLES constants.
REQ-028 Sub-module pb_cond (synchronizer, debounce counter, edge detector) SHALL be instantiated once per button.
REQ-029 All outputs SHALL be registered.

Verification (bench drives slowen every 4 clks, NPOS=7, DEB_SAMPLES=3)
REQ-030 Reset -> leds=7'b0001000, winners 0; pbl glitch of 2 slowen periods -> no move.
REQ-031 pbl held 3 slowen periods, released -> one press, leds=7'b0010000 one clk after pulse; holding longer -> no further move.
REQ-032 pbl and pbr rising in same clk, both held -> leds unchanged, state WAIT_REL until both released.
REQ-033 Four counted pbl presses from centre -> leds=7'b1000000 then WIN_L, winner_l=1, leds[6] toggling per slowen; restart -> leds=7'b0001000, winner_l=0.
REQ-034 Four counted pbr presses -> WIN_R, winner_r=1; restart while pbr still held -> no press until released and re-pressed.
REQ-035 rst asserted with pos=5 and pbl mid-debounce -> centre immediately, no press after release of rst unless pbl stable 3 more strobes.
